// File: rtl/native2axil_if.sv
// AXI4-Lite bus bundle between the native2axil bridge (master side) and a register slave.
// Signal names follow the AXI_* port naming of the bridge.
interface native2axil_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   AXI_AWADDR;
    logic [2:0]              AXI_AWPROT;
    logic                    AXI_AWVALID;
    logic                    AXI_AWREADY;

    logic [DATA_WIDTH-1:0]   AXI_WDATA;
    logic [DATA_WIDTH/8-1:0] AXI_WSTRB;
    logic                    AXI_WVALID;
    logic                    AXI_WREADY;

    logic [1:0]              AXI_BRESP;
    logic                    AXI_BVALID;
    logic                    AXI_BREADY;

    logic [ADDR_WIDTH-1:0]   AXI_ARADDR;
    logic [2:0]              AXI_ARPROT;
    logic                    AXI_ARVALID;
    logic                    AXI_ARREADY;

    logic [DATA_WIDTH-1:0]   AXI_RDATA;
    logic [1:0]              AXI_RRESP;
    logic                    AXI_RVALID;
    logic                    AXI_RREADY;

    modport master (
        output AXI_AWADDR, AXI_AWPROT, AXI_AWVALID,
        input  AXI_AWREADY,
        output AXI_WDATA, AXI_WSTRB, AXI_WVALID,
        input  AXI_WREADY,
        input  AXI_BRESP, AXI_BVALID,
        output AXI_BREADY,
        output AXI_ARADDR, AXI_ARPROT, AXI_ARVALID,
        input  AXI_ARREADY,
        input  AXI_RDATA, AXI_RRESP, AXI_RVALID,
        output AXI_RREADY
    );

    modport slave (
        input  AXI_AWADDR, AXI_AWPROT, AXI_AWVALID,
        output AXI_AWREADY,
        input  AXI_WDATA, AXI_WSTRB, AXI_WVALID,
        output AXI_WREADY,
        output AXI_BRESP, AXI_BVALID,
        input  AXI_BREADY,
        input  AXI_ARADDR, AXI_ARPROT, AXI_ARVALID,
        output AXI_ARREADY,
        output AXI_RDATA, AXI_RRESP, AXI_RVALID,
        input  AXI_RREADY
    );
endinterface

// File: rtl/native2axil.sv
// AXI4-Lite master bridge: turns single-cycle native write/read pulses into one outstanding
// AXI4-Lite transaction and reports completion, read data and response codes back.
module native2axil #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    AXI_ACLK,
    input  logic                    AXI_ARESET,

    input  logic                    WEN,
    input  logic [ADDR_WIDTH-1:0]   WADDR,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    REN,
    input  logic [ADDR_WIDTH-1:0]   RADDR,

    output logic                    BUSY,
    output logic                    WACK,
    output logic [1:0]              WRESP,
    output logic                    RVALID,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    DROP,

    native2axil_if.master           axi
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] WRITE      = 3'd1;
    localparam logic [2:0] WRITE_RESP = 3'd2;
    localparam logic [2:0] READ_ADDR  = 3'd3;
    localparam logic [2:0] READ_DATA  = 3'd4;

    logic [2:0]            state_q,     state_d;
    logic                  pend_q,      pend_d;
    logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;

    logic [ADDR_WIDTH-1:0] awaddr_q,  awaddr_d;
    logic                  awvalid_q, awvalid_d;
    logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q,   wstrb_d;
    logic                  wvalid_q,  wvalid_d;
    logic                  bready_q,  bready_d;
    logic [ADDR_WIDTH-1:0] araddr_q,  araddr_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q,  rready_d;

    logic                  wack_q,    wack_d;
    logic [1:0]            wresp_q,   wresp_d;
    logic                  rvalid_q,  rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
    logic [1:0]            rresp_q,   rresp_d;
    logic                  drop_q,    drop_d;

    logic                  busy;
    logic                  aw_done;
    logic                  w_done;

    assign busy = (state_q != IDLE) || pend_q;

    // A channel counts as done once its VALID has been retired or is handshaking now.
    assign aw_done = !awvalid_q || axi.AXI_AWREADY;
    assign w_done  = !wvalid_q  || axi.AXI_WREADY;

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        awaddr_d    = awaddr_q;
        awvalid_d   = awvalid_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        araddr_d    = araddr_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        wack_d      = 1'b0;
        wresp_d     = wresp_q;
        rvalid_d    = 1'b0;
        rdata_d     = rdata_q;
        rresp_d     = rresp_q;
        drop_d      = (WEN || REN) && busy;

        case (state_q)
            IDLE: begin
                if (pend_q) begin
                    // The WACK cycle itself is skipped so the deferred read starts one cycle later.
                    if (!wack_q) begin
                        araddr_d  = pend_addr_q;
                        arvalid_d = 1'b1;
                        pend_d    = 1'b0;
                        state_d   = READ_ADDR;
                    end
                end else if (WEN) begin
                    awaddr_d  = WADDR;
                    wdata_d   = WDATA;
                    wstrb_d   = WSTRB;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = WRITE;
                    if (REN) begin
                        pend_d      = 1'b1;
                        pend_addr_d = RADDR;
                    end
                end else if (REN) begin
                    araddr_d  = RADDR;
                    arvalid_d = 1'b1;
                    state_d   = READ_ADDR;
                end
            end

            WRITE: begin
                if (awvalid_q && axi.AXI_AWREADY) begin
                    awvalid_d = 1'b0;
                end
                if (wvalid_q && axi.AXI_WREADY) begin
                    wvalid_d = 1'b0;
                end
                if (aw_done && w_done) begin
                    bready_d = 1'b1;
                    state_d  = WRITE_RESP;
                end
            end

            WRITE_RESP: begin
                if (bready_q && axi.AXI_BVALID) begin
                    wresp_d  = axi.AXI_BRESP;
                    wack_d   = 1'b1;
                    bready_d = 1'b0;
                    state_d  = IDLE;
                end
            end

            READ_ADDR: begin
                if (arvalid_q && axi.AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = READ_DATA;
                end
            end

            READ_DATA: begin
                if (rready_q && axi.AXI_RVALID) begin
                    rdata_d  = axi.AXI_RDATA;
                    rresp_d  = axi.AXI_RRESP;
                    rvalid_d = 1'b1;
                    rready_d = 1'b0;
                    state_d  = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge AXI_ACLK) begin
        if (AXI_ARESET) begin
            state_q     <= IDLE;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            awaddr_q    <= '0;
            awvalid_q   <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            araddr_q    <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            wack_q      <= 1'b0;
            wresp_q     <= 2'b00;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            rresp_q     <= 2'b00;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            awaddr_q    <= awaddr_d;
            awvalid_q   <= awvalid_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            araddr_q    <= araddr_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            wack_q      <= wack_d;
            wresp_q     <= wresp_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            rresp_q     <= rresp_d;
            drop_q      <= drop_d;
        end
    end

    assign BUSY   = busy;
    assign WACK   = wack_q;
    assign WRESP  = wresp_q;
    assign RVALID = rvalid_q;
    assign RDATA  = rdata_q;
    assign RRESP  = rresp_q;
    assign DROP   = drop_q;

    assign axi.AXI_AWADDR  = awaddr_q;
    assign axi.AXI_AWPROT  = 3'b000;
    assign axi.AXI_AWVALID = awvalid_q;
    assign axi.AXI_WDATA   = wdata_q;
    assign axi.AXI_WSTRB   = wstrb_q;
    assign axi.AXI_WVALID  = wvalid_q;
    assign axi.AXI_BREADY  = bready_q;
    assign axi.AXI_ARADDR  = araddr_q;
    assign axi.AXI_ARPROT  = 3'b000;
    assign axi.AXI_ARVALID = arvalid_q;
    assign axi.AXI_RREADY  = rready_q;
endmodule
